// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: register file with one-cycle bypassed reads and a pending-write scoreboard that stalls RAW/WAW issues.
module regfile_scoreboard #(
  parameter int DATA_W = 32,
  parameter int NREG   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en_RF,
  input  logic [3:0]               wr_addr,
  input  logic signed [DATA_W-1:0] data_RF,
  input  logic                     rd_en,
  input  logic [3:0]               rd_addrA,
  input  logic [3:0]               rd_addrB,
  output logic signed [DATA_W-1:0] rd_dataA,
  output logic signed [DATA_W-1:0] rd_dataB,
  output logic                     rd_valid,
  input  logic                     issue_valid,
  input  logic                     issue_wr,
  input  logic [3:0]               issue_dest,
  output logic                     stall
);
  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];
  logic [NREG-1:0] pend_q, pend_d, wr_hot, busy;
  logic [DATA_W-1:0] rd_a_q, rd_a_d, rd_b_q, rd_b_d;
  logic rd_valid_q, rd_valid_d;
  always_comb begin
    regs_d = regs_q;
    if (en_RF) regs_d[wr_addr] = data_RF;
    rd_a_d = rd_en ? ((en_RF && wr_addr == rd_addrA) ? data_RF : regs_q[rd_addrA]) : rd_a_q;
    rd_b_d = rd_en ? ((en_RF && wr_addr == rd_addrB) ? data_RF : regs_q[rd_addrB]) : rd_b_q;
    rd_valid_d = rd_en;
    wr_hot = en_RF ? ({{(NREG-1){1'b0}}, 1'b1} << wr_addr) : '0;
    busy = pend_q & ~wr_hot;
    stall = issue_valid & (busy[rd_addrA] | busy[rd_addrB] | (issue_wr & busy[issue_dest]));
    pend_d = busy;
    if (issue_valid && issue_wr && !stall) pend_d[issue_dest] = 1'b1;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      pend_q     <= '0;
      rd_a_q     <= '0;
      rd_b_q     <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      regs_q     <= regs_d;
      pend_q     <= pend_d;
      rd_a_q     <= rd_a_d;
      rd_b_q     <= rd_b_d;
      rd_valid_q <= rd_valid_d;
    end
  end
  assign rd_dataA = rd_a_q;
  assign rd_dataB = rd_b_q;
  assign rd_valid = rd_valid_q;
endmodule

// File: doc/regfile_scoreboard.md
REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register and port data width.
REQ-002 SHALL have parameter NREG, default 16, number of registers; addresses are 4 bits wide.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-low reset (rst=0 resets).
REQ-005 SHALL have port en_RF, input, 1 bit: write enable from the writeback stage.
REQ-006 SHALL have port wr_addr, input, 4 bits: destination register of the write.
REQ-007 SHALL have port data_RF, input, DATA_W bits, signed: write data.
REQ-008 SHALL have port rd_en, input, 1 bit: read request for both read ports.
REQ-009 SHALL have ports rd_addrA and rd_addrB, input, 4 bits each: source register addresses.
REQ-010 SHALL have ports rd_dataA and rd_dataB, output, DATA_W bits each, signed: registered read data.
REQ-011 SHALL have port rd_valid, output, 1 bit: rd_dataA/B are valid this cycle.
REQ-012 SHALL have port issue_valid, input, 1 bit: decode requests issue of an instruction.
REQ-013 SHALL have port issue_wr, input, 1 bit: the issuing instruction writes a register (math/logical or LDW).
REQ-014 SHALL have port issue_dest, input, 4 bits: destination of the issuing instruction.
REQ-015 SHALL have port stall, output, 1 bit, combinational: issue refused this cycle.

Function
REQ-016 SHALL hold NREG x DATA_W storage plus a NREG-bit pending vector (scoreboard).
REQ-017 SHALL, on a clock edge with en_RF=1, write data_RF into register wr_addr and clear pending[wr_addr].
REQ-018 SHALL, on a clock edge with rd_en=1, capture register[rd_addrA] into rd_dataA and register[rd_addrB] into rd_dataB, and assert rd_valid for exactly the next cycle; latency is 1 cycle.
REQ-019 SHALL bypass: if en_RF=1 and wr_addr equals a read address on the same edge, the captured value is data_RF, not the old contents.
REQ-020 SHALL hold rd_dataA/B unchanged and drive rd_valid=0 on edges with rd_en=0.
REQ-021 SHALL assert stall when issue_valid=1 and any of the following is true for a register whose pending bit is set and which is not being written this cycle (en_RF=1 with matching wr_addr): it equals rd_addrA or rd_addrB (RAW hazard), or issue_wr=1 and it equals issue_dest (WAW hazard).
REQ-022 SHALL drive stall=0 whenever issue_valid=0.
REQ-023 SHALL, on an edge with issue_valid=1, issue_wr=1 and stall=0, set pending[issue_dest].
REQ-024 SHALL let the set win when an issue sets and a write clears the same pending bit on the same edge; the bit ends at 1.
REQ-025 SHALL never change a register or pending bit on a stalled issue.
REQ-026 SHALL leave the pending vector unchanged when en_RF=1 targets a non-pending register; the data is still written.
REQ-027 SHALL keep rd_en independent of stall; decode gates rd_en with stall.

Reset
REQ-028 SHALL, while rst=0 and independent of clk, force all registers to 0, the pending vector to 0, rd_dataA/B to 0 and rd_valid to 0; stall is therefore 0.
REQ-029 SHALL discard any write or issue presented on the edge coincident with reset release; the first effective edge is the one after rst rises.
REQ-030 SHALL, when reset is asserted mid-operation, clear all pending hazards, so no stall persists after reset.

Verification
REQ-031 SHALL cover write then read: write R3=0x0000_00A5, then rd_en with rd_addrA=3 on the next cycle -> rd_dataA=0x0000_00A5 one cycle later, rd_valid=1 for one cycle.
REQ-032 SHALL cover bypass: en_RF=1, wr_addr=5, data_RF=-7 on the same edge as rd_en, rd_addrB=5 -> rd_dataB=-7.
REQ-033 SHALL cover RAW stall and release: issue dest=2 (issue_wr=1), then issue with rd_addrA=2 -> stall=1; in the cycle en_RF=1, wr_addr=2 -> stall=0 and pending[2] is cleared after the edge.
REQ-034 SHALL cover WAW and set-wins: pending[4]=1 and a new issue with dest=4 -> stall=1; on an edge with en_RF=1, wr_addr=4 plus a fresh issue dest=4 -> pending[4]=1 after the edge.
REQ-035 SHALL cover async reset: with R1=0x1234 and pending[6]=1, pulse rst=0 between clock edges -> rd_dataA/B=0, rd_valid=0, stall=0 immediately; a read of R1 after release returns 0.
